// File: rtl/pr_hazard_ctrl.sv
// Pipeline-register hold/reset controller: branch flush, load-use stall, MUL/DIV stall, DMEM freeze.
// Optional performance counters are built only when HAZ_PERF_CNT_EN is defined.
//
//   state  | meaning
//   IDLE   | no MUL/DIV in progress; a new MD_START may begin a stall
//   BUSY   | MUL/DIV op held in EX; md_cnt counts the remaining stall cycles
module pr_hazard_ctrl #(
  parameter int NUM_PR     = 4,
  parameter int BJ_FLUSH_N = 2,
  parameter int MD_LAT     = 4,
  parameter int CNT_W      = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              BJ_SIG,
  input  logic              LU_HAZ_SIG,
  input  logic              MD_START,
  input  logic              DMEM_BUSY,
  output logic              PC_HOLD,
  output logic [NUM_PR-1:0] PR_HOLD,
  output logic [NUM_PR-1:0] PR_RES,
  output logic              MD_BUSY,
  output logic [CNT_W-1:0]  STALL_CNT,
  output logic [CNT_W-1:0]  FLUSH_CNT
);

  localparam int MD_CNT_W = $clog2(MD_LAT) + 1;
  localparam bit MD_STALLS = (MD_LAT >= 2);
  localparam bit MD_MULTI  = (MD_LAT >= 3);
  // IDLE covers the first stall cycle and BUSY the final one, hence the -3
  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_MULTI ? MD_CNT_W'(MD_LAT - 3) : '0;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t              state;
  logic [MD_CNT_W-1:0] md_cnt;
  logic                md_busy_q;
  logic                md_stall;

  assign md_stall = (state == S_BUSY) || (MD_START && MD_STALLS);
  assign MD_BUSY  = md_busy_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      md_cnt    <= '0;
      md_busy_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (MD_START && MD_MULTI && !DMEM_BUSY) begin
            state     <= S_BUSY;
            md_cnt    <= MD_LOAD;
            md_busy_q <= 1'b1;
          end
        end
        S_BUSY: begin
          if (!DMEM_BUSY) begin
            if (md_cnt == '0) begin
              state     <= S_IDLE;
              md_busy_q <= 1'b0;
            end else begin
              md_cnt <= md_cnt - 1'b1;
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          md_busy_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    PC_HOLD = 1'b0;
    PR_HOLD = '0;
    PR_RES  = '0;
    if (DMEM_BUSY) begin
      PC_HOLD = 1'b1;
      PR_HOLD = '1;
    end else if (md_stall) begin
      PC_HOLD    = 1'b1;
      PR_HOLD[0] = 1'b1;
      PR_HOLD[1] = 1'b1;
      PR_RES[2]  = 1'b1;
    end else if (BJ_SIG) begin
      for (int i = 0; i < BJ_FLUSH_N; i++) PR_RES[i] = 1'b1;
    end else if (LU_HAZ_SIG) begin
      PC_HOLD    = 1'b1;
      PR_HOLD[0] = 1'b1;
      PR_RES[1]  = 1'b1;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic             bj_take;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  assign bj_take = BJ_SIG && !DMEM_BUSY && !md_stall;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (PC_HOLD && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (bj_take && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign STALL_CNT = stall_cnt_q;
  assign FLUSH_CNT = flush_cnt_q;
`else
  assign STALL_CNT = '0;
  assign FLUSH_CNT = '0;
`endif

endmodule

// File: tb/tb_pr_hazard_ctrl.sv
// Self-checking bench for pr_hazard_ctrl: MD_LAT=4 and MD_LAT=1 instances share stimulus,
// compared every cycle against a remaining-stall-cycles model plus literal spot checks.
module tb_pr_hazard_ctrl;

`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int CW  = 4;
  localparam int BJN = 2;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst, bj, lu, md, dm;
  logic          pc_hold [2];
  logic [3:0]    pr_hold [2];
  logic [3:0]    pr_res  [2];
  logic          md_busy [2];
  logic [CW-1:0] stall_cnt [2];
  logic [CW-1:0] flush_cnt [2];

  int n_pass = 0, n_total = 0;
  bit valid = 1'b0;
  int left [2];
  int sc [2];
  int fc [2];

  always #5 clk = ~clk;

  pr_hazard_ctrl #(.NUM_PR(4), .BJ_FLUSH_N(BJN), .MD_LAT(4), .CNT_W(CW)) u_dut4 (
    .CLK(clk), .RESET(rst), .BJ_SIG(bj), .LU_HAZ_SIG(lu), .MD_START(md), .DMEM_BUSY(dm),
    .PC_HOLD(pc_hold[0]), .PR_HOLD(pr_hold[0]), .PR_RES(pr_res[0]), .MD_BUSY(md_busy[0]),
    .STALL_CNT(stall_cnt[0]), .FLUSH_CNT(flush_cnt[0]));

  pr_hazard_ctrl #(.NUM_PR(4), .BJ_FLUSH_N(BJN), .MD_LAT(1), .CNT_W(CW)) u_dut1 (
    .CLK(clk), .RESET(rst), .BJ_SIG(bj), .LU_HAZ_SIG(lu), .MD_START(md), .DMEM_BUSY(dm),
    .PC_HOLD(pc_hold[1]), .PR_HOLD(pr_hold[1]), .PR_RES(pr_res[1]), .MD_BUSY(md_busy[1]),
    .STALL_CNT(stall_cnt[1]), .FLUSH_CNT(flush_cnt[1]));

  function automatic int lat_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // Model: "left" is the number of MD stall cycles still owed after the current one.
  function automatic bit m_mds(input int lat, input int lft);
    return (lft > 0) || (md && lat >= 2);
  endfunction

  function automatic bit m_pc(input int lat, input int lft);
    return dm || m_mds(lat, lft) || (!bj && lu);
  endfunction

  function automatic logic [3:0] m_hold(input int lat, input int lft);
    if (dm) return 4'b1111;
    if (m_mds(lat, lft)) return 4'b0011;
    if (bj) return 4'b0000;
    if (lu) return 4'b0001;
    return 4'b0000;
  endfunction

  function automatic logic [3:0] m_res(input int lat, input int lft);
    if (dm) return 4'b0000;
    if (m_mds(lat, lft)) return 4'b0100;
    if (bj) return 4'((1 << BJN) - 1);
    if (lu) return 4'b0010;
    return 4'b0000;
  endfunction

  function automatic bit m_flush(input int lat, input int lft);
    return !dm && !m_mds(lat, lft) && bj;
  endfunction

  function automatic int m_next_left(input int lat, input int lft);
    if (dm) return lft;
    if (lft > 0) return lft - 1;
    if (md && lat >= 2) return lat - 2;
    return 0;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    if (rst) valid <= 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        left[i] <= 0;
        sc[i]   <= 0;
        fc[i]   <= 0;
      end else begin
        if (m_pc(lat_of(i), left[i]) && sc[i] < SAT) sc[i] <= sc[i] + 1;
        if (m_flush(lat_of(i), left[i]) && fc[i] < SAT) fc[i] <= fc[i] + 1;
        left[i] <= m_next_left(lat_of(i), left[i]);
      end
    end
  end

  always @(negedge clk) begin
    if (valid) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("pc_hold[%0d]", i), pc_hold[i], m_pc(lat_of(i), left[i]));
        chk($sformatf("pr_hold[%0d]", i), pr_hold[i], m_hold(lat_of(i), left[i]));
        chk($sformatf("pr_res[%0d]", i), pr_res[i], m_res(lat_of(i), left[i]));
        chk($sformatf("hold_res_excl[%0d]", i), pr_hold[i] & pr_res[i], 0);
        chk($sformatf("md_busy[%0d]", i), md_busy[i], left[i] > 0);
        chk($sformatf("stall_cnt[%0d]", i), stall_cnt[i], PERF ? sc[i] : 0);
        chk($sformatf("flush_cnt[%0d]", i), flush_cnt[i], PERF ? fc[i] : 0);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit b, input bit l, input bit m, input bit d);
    bj = b; lu = l; md = m; dm = d;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive(0, 0, 0, 0);
    tick;
    rst = 1'b0;
  endtask

  initial begin
    int pcn, pcn1, bn, frz;
    rst = 1'b1;
    drive(0, 0, 0, 0);
    tick;
    tick;
    rst = 1'b0;

    // reset state
    chk("rst_pc_hold", pc_hold[0], 0);
    chk("rst_pr_hold", pr_hold[0], 0);
    chk("rst_md_busy", md_busy[0], 0);
    chk("rst_stall_cnt", stall_cnt[0], 0);

    // branch/jump flush
    drive(1, 0, 0, 0);
    #1;
    chk("bj_pr_res", pr_res[0], 4'b0011);
    chk("bj_pc_hold", pc_hold[0], 0);
    chk("bj_pr_hold", pr_hold[0], 0);
    tick;
    drive(0, 0, 0, 0);
    #1;
    chk("bj_flush_cnt", flush_cnt[0], PERF ? 1 : 0);

    // load-use, then load-use together with branch
    drive(0, 1, 0, 0);
    #1;
    chk("lu_pc_hold", pc_hold[0], 1);
    chk("lu_pr_hold", pr_hold[0], 4'b0001);
    chk("lu_pr_res", pr_res[0], 4'b0010);
    tick;
    drive(1, 1, 0, 0);
    #1;
    chk("lubj_pr_res", pr_res[0], 4'b0011);
    chk("lubj_pc_hold", pc_hold[0], 0);
    tick;

    // MUL/DIV with MD_START held 3 cycles
    do_reset;
    pcn = 0; pcn1 = 0; bn = 0;
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, k < 3, 0);
      #1;
      if (k == 0) begin
        chk("md_pr_hold", pr_hold[0], 4'b0011);
        chk("md_pr_res", pr_res[0], 4'b0100);
      end
      pcn += int'(pc_hold[0]);
      pcn1 += int'(pc_hold[1]) + int'(md_busy[1]);
      bn += int'(md_busy[0]);
      tick;
    end
    chk("md_stall_cycles", pcn, 3);
    chk("md_busy_cycles", bn, 2);
    chk("md_lat1_no_stall", pcn1, 0);
    chk("md_stall_cnt", stall_cnt[0], PERF ? 3 : 0);

    // DMEM freeze in the middle of a MUL/DIV stall
    do_reset;
    pcn = 0; frz = 0;
    for (int k = 0; k < 7; k++) begin
      drive(0, 0, k < 5, (k == 1) || (k == 2));
      #1;
      pcn += int'(pc_hold[0]);
      frz += int'(pr_hold[0] == 4'b1111);
      tick;
    end
    chk("frz_pc_hold_cycles", pcn, 5);
    chk("frz_full_cycles", frz, 2);

    // reset while BUSY
    do_reset;
    drive(0, 0, 1, 0);
    tick;
    chk("rb_busy_before", md_busy[0], 1);
    rst = 1'b1;
    drive(0, 0, 0, 0);
    tick;
    rst = 1'b0;
    #1;
    chk("rb_md_busy", md_busy[0], 0);
    chk("rb_pc_hold", pc_hold[0], 0);
    chk("rb_stall_cnt", stall_cnt[0], 0);
    tick;

    // counter saturation
    do_reset;
    for (int k = 0; k < 20; k++) begin
      drive(0, 1, 0, 0);
      tick;
    end
    for (int k = 0; k < 20; k++) begin
      drive(1, 0, 0, 0);
      tick;
    end
    drive(0, 0, 0, 0);
    #1;
    chk("sat_stall_cnt", stall_cnt[0], PERF ? 15 : 0);
    chk("sat_flush_cnt", flush_cnt[0], PERF ? 15 : 0);
    tick;
    tick;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pr_hazard_ctrl.md
# pr_hazard_ctrl

Parametrised pipeline-register hold/reset controller for the RV32IM core. It replaces the single-cycle branch/load-use flush logic with a generalised controller covering N pipeline registers, branch/jump flushes, load-use stalls, multi-cycle MUL/DIV stalls tracked by an internal FSM and counter, and data-memory wait freezes. It sits beside the hazard detection and branch logic and drives the PC hold input plus every pipeline register's hold and reset inputs.

## Interface
Parameters:
- NUM_PR, 4, number of pipeline registers; index 0 = IF/ID, 1 = ID/EX, 2 = EX/MEM, 3 = MEM/WB; legal 3..8
- BJ_FLUSH_N, 2, number of PRs, counted from index 0, reset on a branch/jump; legal 1..NUM_PR-1
- MD_LAT, 4, MUL/DIV execute latency in cycles; legal 1..16
- CNT_W, 32, performance counter width

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- BJ_SIG  in  1  branch/jump taken, resolved in EX
- LU_HAZ_SIG  in  1  load-use hazard detected in ID
- MD_START  in  1  MUL/DIV instruction present in EX this cycle
- DMEM_BUSY  in  1  data memory not ready; MEM stage must wait
- PC_HOLD  out  1  PC must not update
- PR_HOLD  out  NUM_PR  per-PR hold
- PR_RES  out  NUM_PR  per-PR synchronous clear to bubble
- MD_BUSY  out  1  FSM in BUSY state
- STALL_CNT  out  CNT_W  stall cycles counted
- FLUSH_CNT  out  CNT_W  branch/jump flushes counted

## Operation
- FSM states: IDLE, BUSY. Down-counter MD_CNT, width clog2(MD_LAT)+1.
- IDLE -> BUSY when MD_START=1, MD_LAT>=3, DMEM_BUSY=0; MD_CNT loaded with MD_LAT-3.
- BUSY: when DMEM_BUSY=0, MD_CNT=0 -> IDLE, else decrement. When DMEM_BUSY=1, state and MD_CNT hold.
- MD stall = (IDLE and MD_START and MD_LAT>=2) or BUSY. Total MD stall cycles = MD_LAT-1, excluding freeze cycles. MD_LAT=1: never stalls, FSM stays IDLE.
- Output decode is combinational from inputs and state. Priority, highest first:
  1. DMEM_BUSY: PC_HOLD=1, PR_HOLD all 1, PR_RES all 0.
  2. MD stall: PC_HOLD=1; PR_HOLD[0]=PR_HOLD[1]=1; PR_RES[2]=1; all other bits 0.
  3. BJ_SIG: PR_RES[BJ_FLUSH_N-1:0]=1; PC_HOLD=0; PR_HOLD all 0.
  4. LU_HAZ_SIG: PC_HOLD=1, PR_HOLD[0]=1, PR_RES[1]=1.
  5. Otherwise all outputs 0.
- BJ_SIG and LU_HAZ_SIG are ignored while an MD stall is active (EX holds the MUL/DIV op, so neither is legitimate).
- PR_HOLD and PR_RES are never both 1 on the same bit.
- STALL_CNT increments on every cycle with PC_HOLD=1. FLUSH_CNT increments on every cycle where priority 3 is taken. Both saturate at all-ones.

## Timing
- Reset (RESET=1 at edge): state IDLE, MD_CNT=0, STALL_CNT=0, FLUSH_CNT=0.
- While RESET=1, combinational outputs still follow the inputs in IDLE. MD_BUSY=0 after reset.
- Zero-cycle latency from any input to PC_HOLD, PR_HOLD and PR_RES.
- MD_BUSY is registered: it rises the cycle after the MD_START edge and falls the cycle after the last stall cycle.
- RESET during BUSY: IDLE at the next edge; the partial stall is abandoned.
- MD_START while BUSY is ignored; it is the same instruction held in EX.

## Configuration
- HAZ_PERF_CNT_EN defined: STALL_CNT and FLUSH_CNT are implemented as described.
- HAZ_PERF_CNT_EN undefined: no counter registers are built, and both ports are tied to 0.

## Test plan
- Reset, then BJ_SIG=1 with BJ_FLUSH_N=2 -> PR_RES=4'b0011, PC_HOLD=0, PR_HOLD=0; FLUSH_CNT=1 next cycle.
- LU_HAZ_SIG=1 for 1 cycle -> PC_HOLD=1, PR_HOLD=4'b0001, PR_RES=4'b0010. LU_HAZ_SIG and BJ_SIG together -> BJ response only.
- MD_LAT=4, MD_START pulse held 3 cycles -> exactly 3 cycles of PC_HOLD=1, PR_HOLD=4'b0011, PR_RES=4'b0100; MD_BUSY high for 2 cycles; STALL_CNT=3. MD_LAT=1 -> no stall.
- MD_LAT=4, DMEM_BUSY=1 for 2 cycles in mid-BUSY -> full freeze (PR_HOLD=4'b1111) for those 2 cycles, then the remaining MD stall completes: total PC_HOLD cycles = 5.
- RESET asserted in BUSY -> MD_BUSY=0 next cycle, outputs 0 with idle inputs, counters 0.
- Counter saturation: CNT_W=4, 20 LU cycles -> STALL_CNT=15. Build without HAZ_PERF_CNT_EN -> both counters read 0.
